// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC frame streamer.
package mfcc_pkg;

  localparam int         NUM_COEFFICIENTS = 12;
  localparam int         CEPS_WIDTH       = 16;
  localparam logic [7:0] HEADER_MAGIC     = 8'hA5;

  // Read-side stream state: idle, header word, coefficient words.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_HEADER,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/mfcc_bank_ram.sv
// Two-bank coefficient register file: one synchronous write port,
// one combinational read port.
module mfcc_bank_ram #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic             w_bank,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_bank,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  // Store a coefficient into the selected bank.
  // NOTE: storage has no reset; validity lives in the top's masks and bank flags,
  // so contents are never read before being written.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (we) mem[w_bank][w_addr] <= w_data;
  end

  assign r_data = mem[r_bank][r_addr];

endmodule

// File: rtl/mfcc_frame_streamer.sv
// Collects DCT coefficients into a ping-pong buffer and streams each
// complete frame out as an optional header word followed by coeff 0..N-1.
module mfcc_frame_streamer
  import mfcc_pkg::*;
#(
  parameter int NUM_COEFFICIENTS = mfcc_pkg::NUM_COEFFICIENTS,
  parameter int CEPS_WIDTH       = mfcc_pkg::CEPS_WIDTH,
  parameter bit HEADER_EN        = 1'b1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                dct_valid_i,
  input  logic [$clog2(NUM_COEFFICIENTS)-1:0] ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0]               ceps_i,
  input  logic                                dct_done_i,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic [CEPS_WIDTH-1:0]               m_data_o,
  output logic                                m_first_o,
  output logic                                m_last_o,
  output logic [CNT_WIDTH-1:0]                frame_count_o,
  output logic [CNT_WIDTH-1:0]                drop_count_o,
  output logic                                incomplete_o
);

  localparam int                PTR_W    = $clog2(NUM_COEFFICIENTS);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_COEFFICIENTS - 1);

  typedef logic [NUM_COEFFICIENTS-1:0] mask_t;

  mask_t            mask_q, mask_next;
  logic             wr_bank_q, rd_bank_q;
  logic [1:0]       bank_full_q;
  logic [7:0]       seq_q;
  logic [7:0]       bank_seq_q [2];
  logic [PTR_W-1:0] idx_q;
  rd_state_e        state_q, state_d, first_state;

  logic                  ptr_ok, wr_en, wb_busy;
  logic                  done_commit, done_drop, done_incomplete;
  logic                  hs, last_hs;
  logic [CEPS_WIDTH-1:0] rd_data;

  // Write bank is only writable while it is not holding a committed frame.
  assign ptr_ok          = 32'(ceps_ptr_i) < NUM_COEFFICIENTS;
  assign wb_busy         = bank_full_q[wr_bank_q];
  assign wr_en           = dct_valid_i & ptr_ok & ~wb_busy;
  assign mask_next       = mask_q | (wr_en ? (mask_t'(1) << ceps_ptr_i) : '0);
  assign done_commit     = dct_done_i & ~wb_busy & (&mask_next);
  assign done_drop       = dct_done_i & ~done_commit;
  assign done_incomplete = dct_done_i & ~wb_busy & ~(&mask_next);

  assign first_state = HEADER_EN ? RD_HEADER : RD_DATA;
  assign hs          = m_valid_o & m_ready_i;
  assign last_hs     = hs & (state_q == RD_DATA) & (idx_q == LAST_IDX);

  mfcc_bank_ram #(
    .DEPTH(NUM_COEFFICIENTS),
    .WIDTH(CEPS_WIDTH),
    .AW   (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .w_bank(wr_bank_q),
    .w_addr(ceps_ptr_i),
    .w_data(ceps_i),
    .r_bank(rd_bank_q),
    .r_addr(idx_q),
    .r_data(rd_data)
  );

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RD_IDLE;
    else        state_q <= state_d;
  end

  // Read FSM next state: start on a committed frame, chain frames with no bubble.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q] || (done_commit && (wr_bank_q == rd_bank_q)))
          state_d = first_state;
      end
      RD_HEADER: begin
        if (hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (last_hs) begin
          if (bank_full_q[~rd_bank_q] || (done_commit && (wr_bank_q != rd_bank_q)))
            state_d = first_state;
          else
            state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Stream outputs decoded from state, read index and the read bank.
  always_comb begin
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_first_o = 1'b0;
    m_last_o  = 1'b0;
    unique case (state_q)
      RD_HEADER: begin
        m_valid_o = 1'b1;
        m_data_o  = CEPS_WIDTH'({HEADER_MAGIC, bank_seq_q[rd_bank_q]});
        m_first_o = 1'b1;
      end
      RD_DATA: begin
        m_valid_o = 1'b1;
        m_data_o  = rd_data;
        m_first_o = !HEADER_EN && (idx_q == '0);
        m_last_o  = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Bank bookkeeping, write mask, sequence tags, read index and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= '0;
      seq_q         <= '0;
      bank_seq_q[0] <= '0;
      bank_seq_q[1] <= '0;
      idx_q         <= '0;
      frame_count_o <= '0;
      drop_count_o  <= '0;
      incomplete_o  <= 1'b0;
    end else begin
      mask_q <= dct_done_i ? '0 : mask_next;

      if (done_commit) begin
        bank_full_q[wr_bank_q] <= 1'b1;
        bank_seq_q[wr_bank_q]  <= seq_q;
        seq_q                  <= seq_q + 8'd1;
        wr_bank_q              <= ~wr_bank_q;
      end

      if (hs && (state_q == RD_DATA))
        idx_q <= last_hs ? '0 : idx_q + PTR_W'(1);

      if (last_hs) begin
        bank_full_q[rd_bank_q] <= 1'b0;
        rd_bank_q              <= ~rd_bank_q;
        frame_count_o          <= frame_count_o + CNT_WIDTH'(1);
      end

      if (done_drop && (drop_count_o != '1))
        drop_count_o <= drop_count_o + CNT_WIDTH'(1);

      if (done_incomplete) incomplete_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mfcc_frame_streamer.sv
// Self-checking bench: randomized frames and stream throttling compared
// against a queue-based model of committed frames.
module tb_mfcc_frame_streamer;

  localparam int N = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dct_valid_i;
  logic [3:0]  ceps_ptr_i;
  logic [15:0] ceps_i;
  logic        dct_done_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [15:0] m_data_o;
  logic        m_first_o;
  logic        m_last_o;
  logic [15:0] frame_count_o;
  logic [15:0] drop_count_o;
  logic        incomplete_o;

  mfcc_frame_streamer #(
    .NUM_COEFFICIENTS(N),
    .CEPS_WIDTH      (16),
    .HEADER_EN       (1'b1),
    .CNT_WIDTH       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dct_valid_i  (dct_valid_i),
    .ceps_ptr_i   (ceps_ptr_i),
    .ceps_i       (ceps_i),
    .dct_done_i   (dct_done_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_first_o    (m_first_o),
    .m_last_o     (m_last_o),
    .frame_count_o(frame_count_o),
    .drop_count_o (drop_count_o),
    .incomplete_o (incomplete_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } word_t;

  // Reference model: frames awaiting output as a flat word queue, plus
  // how many committed frames are still held in the two-frame buffer.
  word_t       exp_q[$];
  int          occ;
  logic [7:0]  m_seq;
  logic [15:0] cur[N];
  int unsigned cur_mask;
  int          m_frames;
  int          m_drops;
  bit          m_incomplete;

  int    ready_mode;  // 0: hold low, 1: hold high, 2: random 30% low
  int    n_checks;
  int    n_fail;
  bit    prev_valid;
  bit    prev_ready;
  word_t prev_word;

  task automatic model_reset();
    exp_q.delete();
    occ          = 0;
    m_seq        = 8'd0;
    cur_mask     = 0;
    m_frames     = 0;
    m_drops      = 0;
    m_incomplete = 1'b0;
    prev_valid   = 1'b0;
    prev_ready   = 1'b0;
    prev_word    = '0;
  endtask

  task automatic model_commit();
    word_t w;
    w = '{data: {8'hA5, m_seq}, first: 1'b1, last: 1'b0};
    exp_q.push_back(w);
    for (int i = 0; i < N; i++) begin
      w = '{data: cur[i], first: 1'b0, last: (i == N - 1)};
      exp_q.push_back(w);
    end
    m_seq = m_seq + 8'd1;
    occ++;
  endtask

  // One clock: check the stream against the model, advance the model over
  // the coming edge, then check the counters after it.
  task automatic step();
    word_t got, exp;
    bit    freed;
    freed = 1'b0;
    case (ready_mode)
      0:       m_ready_i = 1'b0;
      1:       m_ready_i = 1'b1;
      default: m_ready_i = ($urandom_range(0, 99) >= 30);
    endcase
    got = '{data: m_data_o, first: m_first_o, last: m_last_o};

    if (prev_valid && !prev_ready) begin
      n_checks++;
      if (m_valid_o !== 1'b1 || got !== prev_word) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b word=%h/%b/%b, required valid=1 word=%h/%b/%b",
                 m_valid_o, got.data, got.first, got.last,
                 prev_word.data, prev_word.first, prev_word.last);
      end
    end

    if (m_valid_o && m_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h/%b/%b, required no word",
                 got.data, got.first, got.last);
      end else begin
        exp = exp_q.pop_front();
        freed = exp.last;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL stream_word: got %h first=%b last=%b, required %h first=%b last=%b",
                   got.data, got.first, got.last, exp.data, exp.first, exp.last);
        end
      end
    end
    prev_valid = m_valid_o;
    prev_ready = m_ready_i;
    prev_word  = got;

    if (dct_valid_i && int'(ceps_ptr_i) < N && occ < 2) begin
      cur[ceps_ptr_i] = ceps_i;
      cur_mask        = cur_mask | (32'd1 << ceps_ptr_i);
    end
    if (dct_done_i) begin
      if (occ == 2) begin
        if (m_drops != 65535) m_drops++;
      end else if (cur_mask != ((32'd1 << N) - 1)) begin
        if (m_drops != 65535) m_drops++;
        m_incomplete = 1'b1;
      end else begin
        model_commit();
      end
      cur_mask = 0;
    end
    if (freed) begin
      occ--;
      m_frames++;
    end

    @(posedge clk);
    @(negedge clk);

    n_checks++;
    if (frame_count_o !== 16'(m_frames) || drop_count_o !== 16'(m_drops) ||
        incomplete_o !== m_incomplete) begin
      n_fail++;
      $display("FAIL counters: frames=%0d drops=%0d incomplete=%b, required %0d %0d %b",
               frame_count_o, drop_count_o, incomplete_o, m_frames, m_drops, m_incomplete);
    end
  endtask

  task automatic write_coeff(input int ptr, input logic [15:0] val, input bit with_done);
    dct_valid_i = 1'b1;
    ceps_ptr_i  = ptr[3:0];
    ceps_i      = val;
    dct_done_i  = with_done;
    step();
    dct_valid_i = 1'b0;
    dct_done_i  = 1'b0;
  endtask

  task automatic pulse_done();
    dct_done_i = 1'b1;
    step();
    dct_done_i = 1'b0;
  endtask

  // Writes coefficients base+i for ptr 0..nwrite-1, then a done strobe.
  task automatic send_seq_frame(input logic [15:0] base, input int nwrite);
    for (int i = 0; i < nwrite; i++) write_coeff(i, base + 16'(i), 1'b0);
    pulse_done();
  endtask

  // Random values in shuffled order, with junk writes (out-of-range or later
  // overwritten), idle gaps, and sometimes the done on the last write.
  task automatic send_random_frame();
    int order[N];
    int j, t;
    for (int i = 0; i < N; i++) order[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    if ($urandom_range(0, 1) == 1) write_coeff($urandom_range(0, N - 1), 16'($urandom), 1'b0);
    if ($urandom_range(0, 3) == 0) write_coeff($urandom_range(N, 15), 16'($urandom), 1'b0);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1 && $urandom_range(0, 3) == 0) begin
        write_coeff(order[i], 16'($urandom), 1'b1);
        return;
      end
      write_coeff(order[i], 16'($urandom), 1'b0);
      if ($urandom_range(0, 4) == 0) step();
    end
    pulse_done();
  endtask

  task automatic drain(input int mode, input int budget);
    ready_mode = mode;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
    end
    ready_mode = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== 16'h0 || m_first_o !== 1'b0 || m_last_o !== 1'b0 ||
        frame_count_o !== 16'h0 || drop_count_o !== 16'h0 || incomplete_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: valid=%b data=%h first=%b last=%b frames=%0d drops=%0d inc=%b, required all 0",
               name, m_valid_o, m_data_o, m_first_o, m_last_o, frame_count_o, drop_count_o,
               incomplete_o);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    dct_valid_i = 1'b0;
    ceps_ptr_i  = '0;
    ceps_i      = '0;
    dct_done_i  = 1'b0;
    m_ready_i   = 1'b0;
    ready_mode  = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset_release");
  endtask

  task automatic test_single_frame();
    ready_mode = 1;
    send_seq_frame(16'd100, N);
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'hA500 || m_first_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b data=%h first=%b, required 1 a500 1",
               m_valid_o, m_data_o, m_first_o);
    end
    drain(1, 40);
    n_checks++;
    if (frame_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL single_frame_count: %0d, required 1", frame_count_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_mode = 0;
    send_random_frame();
    send_random_frame();
    n_checks++;
    if (drop_count_o !== 16'd0 || m_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_queued: drops=%0d valid=%b, required 0 1", drop_count_o, m_valid_o);
    end
    ready_mode = 1;
    for (int i = 0; i < 2 * (N + 1); i++) begin
      n_checks++;
      if (m_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_no_bubble: valid=%b at word %0d, required 1", m_valid_o, i);
      end
      step();
    end
    drain(1, 10);
    n_checks++;
    if (frame_count_o !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_frame_count: %0d, required 3", frame_count_o);
    end
  endtask

  task automatic test_overflow();
    ready_mode = 0;
    send_seq_frame(16'd300, N);
    send_seq_frame(16'd400, N);
    send_seq_frame(16'd500, N);
    n_checks++;
    if (drop_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL overflow_drop: %0d, required 1", drop_count_o);
    end
    drain(1, 60);
    ready_mode = 1;
    send_seq_frame(16'd600, N);
    n_checks++;
    if (m_data_o !== 16'hA505) begin
      n_fail++;
      $display("FAIL overflow_seq: header=%h, required a505", m_data_o);
    end
    drain(1, 40);
  endtask

  task automatic test_incomplete();
    ready_mode = 1;
    write_coeff(13, 16'hDEAD, 1'b0);
    write_coeff(4, 16'hBEEF, 1'b0);
    send_seq_frame(16'd700, N - 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL incomplete_no_output: valid=%b, required 0", m_valid_o);
      end
      step();
    end
    n_checks++;
    if (incomplete_o !== 1'b1 || drop_count_o !== 16'd2) begin
      n_fail++;
      $display("FAIL incomplete_flag: inc=%b drops=%0d, required 1 2", incomplete_o, drop_count_o);
    end
    write_coeff(4, 16'h1234, 1'b0);
    for (int i = 0; i < N - 1; i++) write_coeff(i, 16'd800 + 16'(i), 1'b0);
    write_coeff(N - 1, 16'd811, 1'b1);
    drain(1, 40);
  endtask

  task automatic test_random_throttle();
    for (int f = 0; f < 50; f++) begin
      ready_mode = 2;
      send_random_frame();
      for (int g = $urandom_range(0, 20); g > 0; g--) step();
    end
    drain(2, 3000);
  endtask

  task automatic test_reset_mid_stream();
    ready_mode = 1;
    send_seq_frame(16'd900, N);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset_outputs");
    model_reset();
    @(negedge clk);
    check_outputs_zero("mid_reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    send_seq_frame(16'd1000, N);
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'hA500) begin
      n_fail++;
      $display("FAIL post_reset_header: valid=%b data=%h, required 1 a500", m_valid_o, m_data_o);
    end
    drain(1, 40);
    n_checks++;
    if (frame_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_frames: %0d, required 1", frame_count_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_incomplete();
    test_random_throttle();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
